// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - serial transmit half of the board UART (8N1, optional even parity)
//
// Converts one byte per DataInValid/DataInReady handshake into an asynchronous
// frame on SOut: start(0), D0..D7 LSB first, [parity], stop(1), each bit held
// SymbolEdgeTime = ClockFreq/BaudRate clock cycles.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// (XOR of D0..D7) between D7 and the stop bit (11-bit frame).
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   synchronous, active-high reset
//   DataIn[7:0]  in   byte to transmit, sampled only on an accepted handshake
//   DataInValid  in   producer has a byte on DataIn
//   DataInReady  out  transmitter idle and able to accept a byte
//   SOut         out  serial line, idle high, driven straight from a register

module uart_transmitter #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut
);

    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int CycleWidth     = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;

`ifdef UART_TX_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif

    localparam logic [CycleWidth-1:0] LastCycle = CycleWidth'(SymbolEdgeTime - 1);
    localparam logic [3:0]            LastBit   = 4'(FrameBits - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]            state;
    logic [FrameBits-1:0]  shift_reg;
    logic [CycleWidth-1:0] cycle_count;
    logic [3:0]            bit_count;
    logic [3:0]            bit_next;
    logic [FrameBits-1:0]  frame_word;

    // Frame is loaded LSB-first so shift_reg[0] is always the bit on the line.
`ifdef UART_TX_PARITY_EN
    assign frame_word = {1'b1, ^DataIn, DataIn, 1'b0};
`else
    assign frame_word = {1'b1, DataIn, 1'b0};
`endif

    assign bit_next = bit_count + 4'd1;

    // The line is the low bit of the shift register; idle keeps it all ones.
    assign SOut = shift_reg[0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            shift_reg   <= '1;
            cycle_count <= '0;
            bit_count   <= 4'd0;
            DataInReady <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (DataInValid && DataInReady) begin
                        shift_reg   <= frame_word;
                        cycle_count <= '0;
                        bit_count   <= 4'd0;
                        DataInReady <= 1'b0;
                        state       <= START;
                    end
                end
                default: begin
                    if (cycle_count == LastCycle) begin
                        cycle_count <= '0;
                        if (bit_count == LastBit) begin
                            // Last stop-bit cycle done: line stays high, ready again.
                            shift_reg   <= '1;
                            bit_count   <= 4'd0;
                            DataInReady <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            // Refill with ones so the stop bit and idle level follow naturally.
                            shift_reg <= {1'b1, shift_reg[FrameBits-1:1]};
                            bit_count <= bit_next;
                            // Parity, when present, rides in DATA; only the final bit is STOP.
                            state     <= (bit_next == LastBit) ? STOP : DATA;
                        end
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
